// File: rtl/ser_port_router_if.sv
// ser_port_router_if
// Bundles the serial-side inputs and the lane-side outputs of ser_port_router.
//   master : drives Clk_EN / SerIn and observes the router outputs (bench side)
//   slave  : the router itself
// Signals:
//   Clk_EN        bit-rate enable
//   SerIn         serial input, idle high
//   out_data      per-lane serial data (NPORTS bits)
//   out_valid     per-lane valid, one-hot or zero
//   ser_out_valid OR of out_valid
//   port_sel      captured destination port
//   busy          router not idle
//   done          frame-complete strobe
//   parity_err    parity failure flag
interface ser_port_router_if #(
    parameter int PORT_BITS = 2
);
    localparam int NPORTS = 1 << PORT_BITS;

    logic                 Clk_EN;
    logic                 SerIn;
    logic [NPORTS-1:0]    out_data;
    logic [NPORTS-1:0]    out_valid;
    logic                 ser_out_valid;
    logic [PORT_BITS-1:0] port_sel;
    logic                 busy;
    logic                 done;
    logic                 parity_err;

    modport master (
        output Clk_EN, SerIn,
        input  out_data, out_valid, ser_out_valid, port_sel, busy, done, parity_err
    );

    modport slave (
        input  Clk_EN, SerIn,
        output out_data, out_valid, ser_out_valid, port_sel, busy, done, parity_err
    );
endinterface

// File: rtl/ser_port_router.sv
// ser_port_router
// Serial frame router: waits for a start bit (SerIn=0), shifts in a
// PORT_BITS destination field and a LEN_BITS length field (both MSB first),
// then steers the next L payload bits onto lane port_sel. A one-cycle DONE
// state follows; a 0 on SerIn during DONE is taken as the next start bit.
// Ports:
//   clk  system clock (rising edge)
//   rst  synchronous active-high reset
//   bus  ser_port_router_if.slave (Clk_EN, SerIn in; lane outputs and status out)
// Optional feature: define SER_PORT_ROUTER_PARITY_EN to add a PAR state that
// samples an even-parity bit covering port, length and payload bits.
module ser_port_router #(
    parameter int PORT_BITS = 2,
    parameter int LEN_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ser_port_router_if.slave     bus
);
    localparam int NPORTS = 1 << PORT_BITS;
    localparam int MAXF   = (PORT_BITS > LEN_BITS) ? PORT_BITS : LEN_BITS;
    localparam int CNT_W  = $clog2(MAXF + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PORT = 3'd1,
        S_LEN  = 3'd2,
        S_XFER = 3'd3,
        S_PAR  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;
    state_t               w_post_data;
    logic [PORT_BITS-1:0] r_port;
    logic [LEN_BITS-1:0]  r_len;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [LEN_BITS-1:0]  r_data_cnt;
    logic [PORT_BITS:0]   w_port_sh;
    logic [LEN_BITS:0]    w_len_sh;
    logic                 w_last_port;
    logic                 w_last_len;
    logic [NPORTS-1:0]    w_out_data;
    logic [NPORTS-1:0]    w_out_valid;

    // Shift candidates include the bit being sampled on this edge, so the
    // zero-length decision sees the complete length field.
    assign w_port_sh   = {r_port, bus.SerIn};
    assign w_len_sh    = {r_len, bus.SerIn};
    assign w_last_port = (r_bit_cnt == CNT_W'(PORT_BITS - 1));
    assign w_last_len  = (r_bit_cnt == CNT_W'(LEN_BITS - 1));

`ifdef SER_PORT_ROUTER_PARITY_EN
    assign w_post_data = S_PAR;
`else
    assign w_post_data = S_DONE;
`endif

    always_comb begin
        w_next = r_state;
        if (bus.Clk_EN) begin
            case (r_state)
                S_IDLE: if (!bus.SerIn) w_next = S_PORT;
                S_PORT: if (w_last_port) w_next = S_LEN;
                S_LEN: begin
                    if (w_last_len)
                        w_next = (w_len_sh[LEN_BITS-1:0] == '0) ? w_post_data : S_XFER;
                end
                S_XFER: if (r_data_cnt == LEN_BITS'(1)) w_next = w_post_data;
`ifdef SER_PORT_ROUTER_PARITY_EN
                S_PAR:  w_next = S_DONE;
`endif
                // A low SerIn during DONE is the next frame's start bit.
                S_DONE: w_next = bus.SerIn ? S_IDLE : S_PORT;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_port     <= '0;
            r_len      <= '0;
            r_bit_cnt  <= '0;
            r_data_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (bus.Clk_EN) begin
                case (r_state)
                    S_PORT: begin
                        r_port    <= w_port_sh[PORT_BITS-1:0];
                        r_bit_cnt <= w_last_port ? '0 : r_bit_cnt + CNT_W'(1);
                    end
                    S_LEN: begin
                        r_len     <= w_len_sh[LEN_BITS-1:0];
                        r_bit_cnt <= w_last_len ? '0 : r_bit_cnt + CNT_W'(1);
                        if (w_last_len) r_data_cnt <= w_len_sh[LEN_BITS-1:0];
                    end
                    S_XFER:  r_data_cnt <= r_data_cnt - LEN_BITS'(1);
                    default: r_bit_cnt  <= '0;
                endcase
            end
        end
    end

`ifdef SER_PORT_ROUTER_PARITY_EN
    logic r_par_acc;
    logic r_par_err;

    // Accumulator runs over port, length and payload bits; the flag is
    // resolved on the PAR edge and held until the next frame starts shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_acc <= 1'b0;
            r_par_err <= 1'b0;
        end else if (bus.Clk_EN) begin
            if (w_next == S_PORT && r_state != S_PORT) begin
                r_par_acc <= 1'b0;
                r_par_err <= 1'b0;
            end else if (r_state == S_PORT || r_state == S_LEN || r_state == S_XFER) begin
                r_par_acc <= r_par_acc ^ bus.SerIn;
            end else if (r_state == S_PAR) begin
                r_par_err <= r_par_acc ^ bus.SerIn;
            end
        end
    end

    assign bus.parity_err = r_par_err;
`else
    assign bus.parity_err = 1'b0;
`endif

    // Payload steering is combinational so the lane sees SerIn in the same cycle.
    always_comb begin
        w_out_data  = '0;
        w_out_valid = '0;
        if (r_state == S_XFER) begin
            w_out_valid[r_port] = 1'b1;
            w_out_data[r_port]  = bus.SerIn;
        end
    end

    assign bus.out_data      = w_out_data;
    assign bus.out_valid     = w_out_valid;
    assign bus.ser_out_valid = |w_out_valid;
    assign bus.port_sel      = r_port;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = (r_state == S_DONE);
endmodule
